ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe_pkg.sv | 31 +++
 rtl/ctrl_stage_reg.sv | 31 +++
 rtl/ctrl_pipe.sv | 127 ++++++++++++
 tb/tb_ctrl_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the ctrl_pipe control pipeline: bus widths, control bit
// positions inside each bus, and the EX operand forwarding encodings.
package ctrl_pipe_pkg;

    localparam int unsigned EXEC_W = 6;
    localparam int unsigned MEM_W  = 3;
    localparam int unsigned WB_W   = 2;
    localparam int unsigned REG_W  = 5;

    localparam int unsigned ALU_SRC_BIT    = 4;
    localparam int unsigned REG_DST_BIT    = 5;
    localparam int unsigned MEM_WRITE_BIT  = 0;
    localparam int unsigned MEM_READ_BIT   = 1;
    localparam int unsigned BRANCH_BIT     = 2;
    localparam int unsigned MEM_TO_REG_BIT = 0;
    localparam int unsigned REG_WRITE_BIT  = 1;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_e;

    // A producer only counts when it is live, writes a register, and that register is not r0.
    function automatic logic raw_match(input logic v, input logic rw,
                                       input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] src);
        return v && rw && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register: valid bit plus payload, with load, bubble and hold.
// Priority inside the stage: rst > hold > bubble > load.
module ctrl_stage_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         bubble,
    input  logic         d_valid,
    input  logic [W-1:0] d,
    output logic         q_valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else if (!hold) begin
            if (bubble) begin
                q_valid <= 1'b0;
                q       <= '0;
            end else begin
                q_valid <= d_valid;
                q       <= d;
            end
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipeline with load-use hazard detection and operand forwarding.
// Build option: define CTRL_PIPE_FWD_EN to enable forwarding (otherwise stall on any RAW).
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned EXEC_BUS_WIDTH = EXEC_W,
    parameter int unsigned MEM_BUS_WIDTH  = MEM_W,
    parameter int unsigned WB_BUS_WIDTH   = WB_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [EXEC_BUS_WIDTH-1:0] id_execute_bus,
    input  logic [MEM_BUS_WIDTH-1:0]  id_memory_bus,
    input  logic [WB_BUS_WIDTH-1:0]   id_wb_bus,
    input  logic [REG_W-1:0]          id_rs,
    input  logic [REG_W-1:0]          id_rt,
    input  logic [REG_W-1:0]          id_rd,
    input  logic                      flush,
    input  logic                      freeze,
    output logic [EXEC_BUS_WIDTH-1:0] ex_execute_bus,
    output logic [MEM_BUS_WIDTH-1:0]  ex_memory_bus,
    output logic [WB_BUS_WIDTH-1:0]   ex_wb_bus,
    output logic [MEM_BUS_WIDTH-1:0]  mem_memory_bus,
    output logic [WB_BUS_WIDTH-1:0]   mem_wb_bus,
    output logic [WB_BUS_WIDTH-1:0]   wb_wb_bus,
    output logic [REG_W-1:0]          ex_dst,
    output logic [REG_W-1:0]          mem_dst,
    output logic [REG_W-1:0]          wb_dst,
    output logic                      hazard_stall,
    output logic [1:0]                fwd_a,
    output logic [1:0]                fwd_b
);

`ifdef CTRL_PIPE_FWD_EN
    localparam int unsigned EX_REGS = 3;
`else
    localparam int unsigned EX_REGS = 1;
`endif
    localparam int unsigned EX_PW  = EXEC_BUS_WIDTH + MEM_BUS_WIDTH + WB_BUS_WIDTH + EX_REGS * REG_W;
    localparam int unsigned MEM_PW = MEM_BUS_WIDTH + WB_BUS_WIDTH + REG_W;
    localparam int unsigned WB_PW  = WB_BUS_WIDTH + REG_W;

    logic                      ex_v, mem_v, wb_v;
    logic [EXEC_BUS_WIDTH-1:0] ex_exec;
    logic [MEM_BUS_WIDTH-1:0]  ex_mem, mem_mem;
    logic [WB_BUS_WIDTH-1:0]   ex_wb, mem_wb, wb_wb;
    logic [REG_W-1:0]          id_dst, ex_dst_r, mem_dst_r, wb_dst_r;
    logic [EX_PW-1:0]          ex_d, ex_q;
    logic [MEM_PW-1:0]         mem_q;
    logic [WB_PW-1:0]          wb_q;
    logic                      raw_hazard;

    assign id_dst = id_execute_bus[REG_DST_BIT] ? id_rt : id_rd;

    // rs/rt only feed the forwarding compare, so EX carries them only when forwarding exists.
`ifdef CTRL_PIPE_FWD_EN
    logic [REG_W-1:0] ex_rs, ex_rt;
    fwd_e             fa, fb;

    assign ex_d = {id_execute_bus, id_memory_bus, id_wb_bus, id_dst, id_rs, id_rt};
    assign {ex_exec, ex_mem, ex_wb, ex_dst_r, ex_rs, ex_rt} = ex_q;

    assign raw_hazard = id_valid && ex_mem[MEM_READ_BIT] &&
        (raw_match(ex_v, ex_wb[REG_WRITE_BIT], ex_dst_r, id_rs) ||
         raw_match(ex_v, ex_wb[REG_WRITE_BIT], ex_dst_r, id_rt));

    always_comb begin
        fa = FWD_RF;
        fb = FWD_RF;
        if (raw_match(mem_v, mem_wb[REG_WRITE_BIT], mem_dst_r, ex_rs))
            fa = FWD_MEM;
        else if (raw_match(wb_v, wb_wb[REG_WRITE_BIT], wb_dst_r, ex_rs))
            fa = FWD_WB;
        if (raw_match(mem_v, mem_wb[REG_WRITE_BIT], mem_dst_r, ex_rt))
            fb = FWD_MEM;
        else if (raw_match(wb_v, wb_wb[REG_WRITE_BIT], wb_dst_r, ex_rt))
            fb = FWD_WB;
    end

    assign fwd_a = fa;
    assign fwd_b = fb;
`else
    assign ex_d = {id_execute_bus, id_memory_bus, id_wb_bus, id_dst};
    assign {ex_exec, ex_mem, ex_wb, ex_dst_r} = ex_q;

    assign raw_hazard = id_valid &&
        (raw_match(ex_v,  ex_wb[REG_WRITE_BIT],  ex_dst_r,  id_rs) ||
         raw_match(ex_v,  ex_wb[REG_WRITE_BIT],  ex_dst_r,  id_rt) ||
         raw_match(mem_v, mem_wb[REG_WRITE_BIT], mem_dst_r, id_rs) ||
         raw_match(mem_v, mem_wb[REG_WRITE_BIT], mem_dst_r, id_rt));

    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    assign hazard_stall = raw_hazard && !flush;

    ctrl_stage_reg #(.W(EX_PW)) u_ex (
        .clk(clk), .rst(rst), .hold(freeze), .bubble(flush || raw_hazard),
        .d_valid(id_valid), .d(ex_d), .q_valid(ex_v), .q(ex_q)
    );

    ctrl_stage_reg #(.W(MEM_PW)) u_mem (
        .clk(clk), .rst(rst), .hold(freeze), .bubble(1'b0),
        .d_valid(ex_v), .d({ex_mem, ex_wb, ex_dst_r}), .q_valid(mem_v), .q(mem_q)
    );

    ctrl_stage_reg #(.W(WB_PW)) u_wb (
        .clk(clk), .rst(rst), .hold(freeze), .bubble(1'b0),
        .d_valid(mem_v), .d({mem_wb, mem_dst_r}), .q_valid(wb_v), .q(wb_q)
    );

    assign {mem_mem, mem_wb, mem_dst_r} = mem_q;
    assign {wb_wb, wb_dst_r}            = wb_q;

    assign ex_execute_bus = ex_v  ? ex_exec   : '0;
    assign ex_memory_bus  = ex_v  ? ex_mem    : '0;
    assign ex_wb_bus      = ex_v  ? ex_wb     : '0;
    assign ex_dst         = ex_v  ? ex_dst_r  : '0;
    assign mem_memory_bus = mem_v ? mem_mem   : '0;
    assign mem_wb_bus     = mem_v ? mem_wb    : '0;
    assign mem_dst        = mem_v ? mem_dst_r : '0;
    assign wb_wb_bus      = wb_v  ? wb_wb     : '0;
    assign wb_dst         = wb_v  ? wb_dst_r  : '0;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: WB arrivals are checked against a scoreboard filled at issue.
// Expectations follow CTRL_PIPE_FWD_EN the same way the design build does.
module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst, id_valid, flush, freeze;
    logic [5:0] id_execute_bus;
    logic [2:0] id_memory_bus;
    logic [1:0] id_wb_bus;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [5:0] ex_execute_bus;
    logic [2:0] ex_memory_bus, mem_memory_bus;
    logic [1:0] ex_wb_bus, mem_wb_bus, wb_wb_bus;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic       hazard_stall;
    logic [1:0] fwd_a, fwd_b;

    ctrl_pipe #(.EXEC_BUS_WIDTH(6), .MEM_BUS_WIDTH(3), .WB_BUS_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_execute_bus(id_execute_bus), .id_memory_bus(id_memory_bus), .id_wb_bus(id_wb_bus),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .freeze(freeze),
        .ex_execute_bus(ex_execute_bus), .ex_memory_bus(ex_memory_bus), .ex_wb_bus(ex_wb_bus),
        .mem_memory_bus(mem_memory_bus), .mem_wb_bus(mem_wb_bus), .wb_wb_bus(wb_wb_bus),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst), .hazard_stall(hazard_stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] ADD_EX = 6'b000010;
    localparam logic [5:0] SUB_EX = 6'b000011;
    localparam logic [5:0] LW_EX  = 6'b110000;
    localparam logic [2:0] LW_ME  = 3'b010;
    localparam logic [1:0] RW_WB  = 2'b10;
    localparam logic [1:0] LW_WB  = 2'b11;
`ifdef CTRL_PIPE_FWD_EN
    localparam int LU_STALLS  = 1;
    localparam int RAW_STALLS = 0;
    localparam logic [1:0] EXP_FWD_WB  = 2'b10;
    localparam logic [1:0] EXP_FWD_MEM = 2'b01;
`else
    localparam int LU_STALLS  = 2;
    localparam int RAW_STALLS = 2;
    localparam logic [1:0] EXP_FWD_WB  = 2'b00;
    localparam logic [1:0] EXP_FWD_MEM = 2'b00;
`endif

    typedef struct packed {
        logic [1:0] wb;
        logic [4:0] dst;
    } exp_t;

    exp_t        sb[$];
    int unsigned total  = 0;
    int unsigned passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        logic skip;
        exp_t e;
        skip = freeze;
        @(posedge clk);
        #1;
        if (!skip && wb_wb_bus !== 2'b00) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_wb", {30'b0, wb_wb_bus}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("sb_wb_bus", {30'b0, wb_wb_bus}, {30'b0, e.wb});
                check("sb_wb_dst", {27'b0, wb_dst}, {27'b0, e.dst});
            end
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0;
        id_execute_bus = '0;
        id_memory_bus = '0;
        id_wb_bus = '0;
        id_rs = '0;
        id_rt = '0;
        id_rd = '0;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [5:0] ex, input logic [2:0] me, input logic [1:0] wb);
        id_valid = 1'b1;
        id_rs = rs;
        id_rt = rt;
        id_rd = rd;
        id_execute_bus = ex;
        id_memory_bus = me;
        id_wb_bus = wb;
    endtask

    task automatic drain();
        idle();
        repeat (3) cyc();
    endtask

    // Holds the issued instruction in ID until hazard_stall drops, then moves it into EX.
    task automatic enter(input string tag, input int exp_stalls, input exp_t e);
        int n;
        n = 0;
        settle();
        while (hazard_stall === 1'b1 && n < 6) begin
            n++;
            cyc();
            check({tag, "_bubble_exec"}, {26'b0, ex_execute_bus}, 32'h0);
            check({tag, "_bubble_wb"}, {30'b0, ex_wb_bus}, 32'h0);
            settle();
        end
        check({tag, "_stalls"}, n, exp_stalls);
        sb.push_back(e);
        cyc();
        check({tag, "_ex_dst"}, {27'b0, ex_dst}, {27'b0, e.dst});
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        freeze = 1'b0;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_ex_exec", {26'b0, ex_execute_bus}, 32'h0);
        check("rst_ex_wb", {30'b0, ex_wb_bus}, 32'h0);
        check("rst_mem_mem", {29'b0, mem_memory_bus}, 32'h0);
        check("rst_wb_wb", {30'b0, wb_wb_bus}, 32'h0);
        check("rst_ex_dst", {27'b0, ex_dst}, 32'h0);
        check("rst_hazard", {31'b0, hazard_stall}, 32'h0);
        check("rst_fwd_a", {30'b0, fwd_a}, 32'h0);
        check("rst_fwd_b", {30'b0, fwd_b}, 32'h0);

        // add r3 travels EX -> MEM -> WB
        issue(5'd1, 5'd2, 5'd3, ADD_EX, 3'b000, RW_WB);
        sb.push_back('{wb: RW_WB, dst: 5'd3});
        cyc();
        idle();
        check("add_ex_exec", {26'b0, ex_execute_bus}, {26'b0, ADD_EX});
        check("add_ex_wb", {30'b0, ex_wb_bus}, {30'b0, RW_WB});
        check("add_ex_dst", {27'b0, ex_dst}, 32'd3);
        cyc();
        check("add_mem_wb", {30'b0, mem_wb_bus}, {30'b0, RW_WB});
        check("add_mem_dst", {27'b0, mem_dst}, 32'd3);
        check("add_ex_empty", {30'b0, ex_wb_bus}, 32'h0);
        cyc();
        check("add_wb_dst", {27'b0, wb_dst}, 32'd3);
        drain();

        // load-use: lw r5 then add reading r5
        issue(5'd1, 5'd5, 5'd9, LW_EX, LW_ME, LW_WB);
        enter("lw", 0, '{wb: LW_WB, dst: 5'd5});
        check("lw_ex_mem", {29'b0, ex_memory_bus}, {29'b0, LW_ME});
        issue(5'd5, 5'd2, 5'd6, ADD_EX, 3'b000, RW_WB);
        enter("ld_use", LU_STALLS, '{wb: RW_WB, dst: 5'd6});
        check("ld_use_fwd_a", {30'b0, fwd_a}, {30'b0, EXP_FWD_WB});
        check("ld_use_fwd_b", {30'b0, fwd_b}, 32'h0);
        drain();

        // back-to-back RAW on both sources
        issue(5'd1, 5'd2, 5'd4, ADD_EX, 3'b000, RW_WB);
        enter("add4", 0, '{wb: RW_WB, dst: 5'd4});
        issue(5'd4, 5'd4, 5'd7, SUB_EX, 3'b000, RW_WB);
        enter("raw", RAW_STALLS, '{wb: RW_WB, dst: 5'd7});
        check("raw_fwd_a", {30'b0, fwd_a}, {30'b0, EXP_FWD_MEM});
        check("raw_fwd_b", {30'b0, fwd_b}, {30'b0, EXP_FWD_MEM});
        drain();

        // MEM wins over WB when both hold r4
        issue(5'd1, 5'd2, 5'd4, ADD_EX, 3'b000, RW_WB);
        enter("pri_old", 0, '{wb: RW_WB, dst: 5'd4});
        issue(5'd3, 5'd3, 5'd4, SUB_EX, 3'b000, RW_WB);
        enter("pri_new", 0, '{wb: RW_WB, dst: 5'd4});
        issue(5'd4, 5'd0, 5'd8, ADD_EX, 3'b000, RW_WB);
        enter("pri_rd", RAW_STALLS, '{wb: RW_WB, dst: 5'd8});
        check("pri_fwd_a", {30'b0, fwd_a}, {30'b0, EXP_FWD_MEM});
        check("pri_fwd_b", {30'b0, fwd_b}, 32'h0);
        drain();

        // flush overrides a pending load-use hazard
        issue(5'd1, 5'd5, 5'd9, LW_EX, LW_ME, LW_WB);
        enter("lw2", 0, '{wb: LW_WB, dst: 5'd5});
        issue(5'd5, 5'd2, 5'd6, ADD_EX, 3'b000, RW_WB);
        flush = 1'b1;
        settle();
        check("flush_hazard", {31'b0, hazard_stall}, 32'h0);
        cyc();
        flush = 1'b0;
        idle();
        check("flush_ex_exec", {26'b0, ex_execute_bus}, 32'h0);
        check("flush_ex_wb", {30'b0, ex_wb_bus}, 32'h0);
        check("flush_mem_dst", {27'b0, mem_dst}, 32'd5);
        check("flush_mem_mem", {29'b0, mem_memory_bus}, {29'b0, LW_ME});
        drain();

        // freeze for three cycles mid-stream
        issue(5'd1, 5'd2, 5'd10, ADD_EX, 3'b000, RW_WB);
        enter("f10", 0, '{wb: RW_WB, dst: 5'd10});
        issue(5'd1, 5'd2, 5'd11, ADD_EX, 3'b000, RW_WB);
        enter("f11", 0, '{wb: RW_WB, dst: 5'd11});
        freeze = 1'b1;
        issue(5'd1, 5'd2, 5'd12, SUB_EX, 3'b000, RW_WB);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("frz_ex_dst", {27'b0, ex_dst}, 32'd11);
            check("frz_mem_dst", {27'b0, mem_dst}, 32'd10);
            check("frz_ex_exec", {26'b0, ex_execute_bus}, {26'b0, ADD_EX});
            check("frz_wb_wb", {30'b0, wb_wb_bus}, 32'h0);
        end
        idle();
        freeze = 1'b0;
        cyc();
        check("frz_rel_wb1", {27'b0, wb_dst}, 32'd10);
        cyc();
        check("frz_rel_wb2", {27'b0, wb_dst}, 32'd11);
        cyc();
        check("frz_rel_empty", {30'b0, wb_wb_bus}, 32'h0);

        // r0 is never a hazard or forwarding source
        issue(5'd1, 5'd2, 5'd0, ADD_EX, 3'b000, RW_WB);
        enter("r0w", 0, '{wb: RW_WB, dst: 5'd0});
        issue(5'd0, 5'd0, 5'd13, ADD_EX, 3'b000, RW_WB);
        enter("r0r", 0, '{wb: RW_WB, dst: 5'd13});
        check("r0_fwd_a", {30'b0, fwd_a}, 32'h0);
        check("r0_fwd_b", {30'b0, fwd_b}, 32'h0);
        drain();

        // reset mid-stream discards in-flight work
        issue(5'd1, 5'd2, 5'd14, ADD_EX, 3'b000, RW_WB);
        cyc();
        issue(5'd1, 5'd2, 5'd15, ADD_EX, 3'b000, RW_WB);
        cyc();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mrst_ex_wb", {30'b0, ex_wb_bus}, 32'h0);
        check("mrst_mem_wb", {30'b0, mem_wb_bus}, 32'h0);
        check("mrst_mem_dst", {27'b0, mem_dst}, 32'h0);
        check("mrst_wb_wb", {30'b0, wb_wb_bus}, 32'h0);
        repeat (3) cyc();

        check("sb_empty", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
